// File: rtl/t02_mem_arbiter_if.sv
// ============================================================================
// Module      : t02_mem_arbiter_if
// Description : Client-side request/completion signals and the shared RAM bus
//               of the t02_mem_arbiter, bundled with an arbiter-side (master)
//               and an environment-side (slave) view.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface t02_mem_arbiter_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Client channels
    logic [NUM_CH-1:0]        ch_req;
    logic [NUM_CH-1:0]        ch_we;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH*DATA_W-1:0] ch_wdata;
    logic [DATA_W-1:0]        ch_rdata;
    logic [NUM_CH-1:0]        ch_ready;
    logic [NUM_CH-1:0]        ch_err;

    // Shared RAM bus
    logic [ADDR_W-1:0]        ramaddr;
    logic [DATA_W-1:0]        ramstore;
    logic                     Ren;
    logic                     Wen;
    logic [DATA_W-1:0]        ramload;
    logic                     busy_o;

    // Arbiter view
    modport master (
        input  ch_req, ch_we, ch_addr, ch_wdata, ramload, busy_o,
        output ch_rdata, ch_ready, ch_err, ramaddr, ramstore, Ren, Wen
    );

    // Clients and RAM bridge view
    modport slave (
        output ch_req, ch_we, ch_addr, ch_wdata, ramload, busy_o,
        input  ch_rdata, ch_ready, ch_err, ramaddr, ramstore, Ren, Wen
    );
endinterface

`default_nettype wire

// File: rtl/t02_mem_arbiter.sv
// ============================================================================
// Module      : t02_mem_arbiter
// Description : Round-robin arbiter placing NUM_CH memory clients onto one
//               shared RAM bus. One outstanding transaction, registered bus
//               outputs, one-cycle per-channel completion pulse.
//               Optional WAIT-state timeout: define T02_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module t02_mem_arbiter #(
    parameter int NUM_CH      = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      enable,
    t02_mem_arbiter_if.master         bus,
    output logic [$clog2(NUM_CH)-1:0] grant_id
);

    localparam int GID_W = $clog2(NUM_CH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [GID_W-1:0]  r_grant;
    logic              r_we;
    logic [ADDR_W-1:0] r_ramaddr;
    logic [DATA_W-1:0] r_ramstore;
    logic              r_ren;
    logic              r_wen;
    logic [DATA_W-1:0] r_rdata;
    logic [NUM_CH-1:0] r_ready;

    logic              w_found;
    logic [GID_W-1:0]  w_next;
    logic [GID_W-1:0]  w_idx;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_sel_we;
    logic              w_timeout;

    // Round-robin scan: first requester above the last grant, wrapping around
    always_comb begin
        w_found = 1'b0;
        w_next  = r_grant;
        w_idx   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            w_idx = GID_W'((int'(r_grant) + k) % NUM_CH);
            if (!w_found && bus.ch_req[w_idx]) begin
                w_found = 1'b1;
                w_next  = w_idx;
            end
        end
    end

    // Pick the winning channel's address, data and direction
    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_we    = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_next == GID_W'(i)) begin
                w_sel_addr  = bus.ch_addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = bus.ch_wdata[i*DATA_W +: DATA_W];
                w_sel_we    = bus.ch_we[i];
            end
        end
    end

`ifdef T02_ARB_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    logic [TO_W-1:0]   r_to_cnt;
    logic [NUM_CH-1:0] r_err;

    // WAIT-cycle counter; zero on entry to ISSUE, counts busy WAIT cycles
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_to_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end else begin
            r_to_cnt <= '0;
        end
    end

    // The last permitted busy WAIT cycle aborts the transaction
    assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

    // One-cycle error pulse for the channel whose transaction timed out
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_err <= '0;
        end else begin
            r_err <= '0;
            if (r_state == S_WAIT && bus.busy_o && w_timeout) begin
                r_err[r_grant] <= 1'b1;
            end
        end
    end

    assign bus.ch_err = r_err;
`else
    logic [31:0] w_unused_timeout;

    assign w_unused_timeout = 32'(TIMEOUT_CYC);
    assign w_timeout        = 1'b0;
    assign bus.ch_err       = '0;
`endif

    // Main transaction FSM and registered bus/client outputs
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state    <= S_IDLE;
            r_grant    <= GID_W'(NUM_CH - 1);
            r_we       <= 1'b0;
            r_ramaddr  <= '0;
            r_ramstore <= '0;
            r_ren      <= 1'b0;
            r_wen      <= 1'b0;
            r_rdata    <= '0;
            r_ready    <= '0;
        end else begin
            r_ready <= '0;
            case (r_state)
                S_IDLE: begin
                    if (enable && w_found) begin
                        r_grant    <= w_next;
                        r_ramaddr  <= w_sel_addr;
                        r_ramstore <= w_sel_wdata;
                        r_we       <= w_sel_we;
                        r_ren      <= ~w_sel_we;
                        r_wen      <= w_sel_we;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // bus busy is not sampled on the first strobe cycle
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!bus.busy_o) begin
                        if (!r_we) begin
                            r_rdata <= bus.ramload;
                        end
                        r_ren            <= 1'b0;
                        r_wen            <= 1'b0;
                        r_ready[r_grant] <= 1'b1;
                        r_state          <= S_DONE;
                    end else if (w_timeout) begin
                        r_ren   <= 1'b0;
                        r_wen   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    // completion cycle: no grant so clients may change requests
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ramaddr  = r_ramaddr;
    assign bus.ramstore = r_ramstore;
    assign bus.Ren      = r_ren;
    assign bus.Wen      = r_wen;
    assign bus.ch_rdata = r_rdata;
    assign bus.ch_ready = r_ready;
    assign grant_id     = r_grant;

endmodule

`default_nettype wire

// File: tb/tb_t02_mem_arbiter.sv
// ============================================================================
// Module      : tb_t02_mem_arbiter
// Description : Self-checking bench for t02_mem_arbiter (NUM_CH=4). Expected
//               completions are queued when a request is driven and compared
//               when ch_ready/ch_err pulse. Timeout scenario runs only when
//               T02_ARB_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_t02_mem_arbiter;

    localparam int NCH = 4;

    typedef struct {
        int          ch;
        bit          err;
        logic [31:0] rdata;
    } exp_t;

    logic        clk;
    logic        nrst;
    logic        enable;
    logic [1:0]  grant_id;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    logic [31:0] model_rdata = '0;
    exp_t        sb_q[$];
    exp_t        mon_e;

    t02_mem_arbiter_if #(.NUM_CH(NCH), .ADDR_W(32), .DATA_W(32)) bus ();

    t02_mem_arbiter #(
        .NUM_CH      (NCH),
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .enable   (enable),
        .bus      (bus),
        .grant_id (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Completion monitor: every ready/err pulse must match the oldest expectation
    always @(negedge clk) begin
        if (nrst && ((bus.ch_ready | bus.ch_err) != '0)) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected", 64'(bus.ch_ready | bus.ch_err), 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.err) begin
                    check("err_vec", 64'(bus.ch_err), 64'd1 << mon_e.ch);
                    check("err_no_ready", 64'(bus.ch_ready), 64'd0);
                end else begin
                    check("ready_vec", 64'(bus.ch_ready), 64'd1 << mon_e.ch);
                    check("ready_no_err", 64'(bus.ch_err), 64'd0);
                end
                check("rdata", 64'(bus.ch_rdata), 64'(mon_e.rdata));
            end
        end
    end

    // Wait (bounded) for the bus strobes that mark the ISSUE cycle
    task automatic wait_issue(output bit seen);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = bus.Ren | bus.Wen;
        end
        check("issue_seen", 64'(seen), 64'd1);
    endtask

    task automatic do_txn(input int ch, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int nbusy,
                          input logic [31:0] load, input bit drop);
        exp_t e;
        bit   seen;
        int   t0;
        e.ch    = ch;
        e.err   = 1'b0;
        e.rdata = we ? model_rdata : load;
        if (!we) model_rdata = load;
        sb_q.push_back(e);

        bus.ch_addr[ch*32 +: 32]  = addr;
        bus.ch_wdata[ch*32 +: 32] = wdata;
        bus.ch_we[ch]             = we;
        bus.ch_req[ch]            = 1'b1;
        bus.ramload               = load;
        bus.busy_o                = 1'b1;

        wait_issue(seen);
        if (!seen) return;
        t0 = cyc;
        check("grant_id", 64'(grant_id), 64'(ch));
        check("issue_addr", 64'(bus.ramaddr), 64'(addr));
        check("issue_strobes", 64'({bus.Ren, bus.Wen}), 64'({!we, we}));
        if (we) check("issue_store", 64'(bus.ramstore), 64'(wdata));
        if (drop) bus.ch_req[ch] = 1'b0;

        @(negedge clk);
        check("wait_strobes", 64'({bus.Ren, bus.Wen}), 64'({!we, we}));
        check("wait_addr", 64'(bus.ramaddr), 64'(addr));
        if (nbusy > 0) begin
            repeat (nbusy) @(posedge clk);
            #1;
        end
        bus.busy_o = 1'b0;

        seen = 1'b0;
        for (int n = 0; n < nbusy + 10 && !seen; n++) begin
            @(negedge clk);
            seen = |bus.ch_ready;
        end
        check("ready_seen", 64'(seen), 64'd1);
        check("latency", 64'(cyc - t0), 64'(nbusy + 2));
        check("done_strobes", 64'({bus.Ren, bus.Wen}), 64'd0);
        bus.ch_req[ch] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        int t_iss;
        int t_rdy;
        exp_t e;

        nrst         = 1'b0;
        enable       = 1'b1;
        bus.ch_req   = 4'b0011;
        bus.ch_we    = 4'b0010;
        bus.ch_addr  = '0;
        bus.ch_wdata = '0;
        bus.ch_addr[0*32 +: 32]  = 32'h0000_0010;
        bus.ch_addr[1*32 +: 32]  = 32'h0000_0100;
        bus.ch_wdata[1*32 +: 32] = 32'h1234_5678;
        bus.ramload  = '0;
        bus.busy_o   = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_strobes", 64'({bus.Ren, bus.Wen}), 64'd0);
        check("rst_addr", 64'(bus.ramaddr), 64'd0);
        check("rst_store", 64'(bus.ramstore), 64'd0);
        check("rst_rdata", 64'(bus.ch_rdata), 64'd0);
        check("rst_ready_err", 64'({bus.ch_ready, bus.ch_err}), 64'd0);
        check("rst_grant", 64'(grant_id), 64'd3);
        @(posedge clk);
        #1 nrst = 1'b1;

        // ch0 first despite ch1 also requesting; then ch1 write
        do_txn(0, 1'b0, 32'h0000_0010, 32'h0, 0, 32'h1111_1111, 1'b0);
        do_txn(1, 1'b1, 32'h0000_0100, 32'h1234_5678, 2, 32'hFFFF_0000, 1'b0);
        // read with 4 busy WAIT cycles
        do_txn(0, 1'b0, 32'h0000_0040, 32'h0, 4, 32'hDEAD_BEEF, 1'b0);

        // enable=0 blocks new grants
        enable = 1'b0;
        bus.ch_req[2] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("dis_no_grant", 64'(bus.Ren | bus.Wen), 64'd0);
        end
        enable = 1'b1;
        do_txn(2, 1'b0, 32'h0000_0200, 32'h0, 1, 32'h2222_2222, 1'b0);

        // request dropped right after issue still completes
        do_txn(3, 1'b1, 32'h0000_0300, 32'hCAFE_F00D, 1, 32'h3333_3333, 1'b1);

        // reset in the middle of WAIT
        bus.ch_req[1] = 1'b1;
        bus.ch_we[1]  = 1'b0;
        bus.busy_o    = 1'b1;
        wait_issue(seen);
        check("rstw_grant", 64'(grant_id), 64'd1);
        repeat (2) @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        check("rstw_strobes", 64'({bus.Ren, bus.Wen}), 64'd0);
        check("rstw_grant_id", 64'(grant_id), 64'd3);
        model_rdata   = '0;
        bus.ch_req    = '0;
        bus.busy_o    = 1'b0;
        @(posedge clk);
        #1 nrst = 1'b1;
        repeat (4) @(negedge clk);
        check("rstw_idle", 64'(bus.Ren | bus.Wen), 64'd0);

        // Fairness: all channels continuously requesting
        for (int i = 0; i < NCH; i++) begin
            bus.ch_addr[i*32 +: 32] = 32'h1000 * (i + 1);
        end
        bus.ch_we   = '0;
        bus.ramload = 32'hA5A5_0000;
        model_rdata = 32'hA5A5_0000;
        for (int i = 0; i < 8; i++) begin
            e.ch = i % NCH; e.err = 1'b0; e.rdata = 32'hA5A5_0000;
            sb_q.push_back(e);
        end
        bus.ch_req = 4'hF;
        t_rdy = 0;
        for (int i = 0; i < 8; i++) begin
            wait_issue(seen);
            t_iss = cyc;
            check("rr_grant", 64'(grant_id), 64'(i % NCH));
            check("rr_addr", 64'(bus.ramaddr), 64'(32'h1000 * ((i % NCH) + 1)));
            if (i > 0) check("rr_gap_ok", 64'((t_iss - t_rdy) >= 2), 64'd1);
            seen = 1'b0;
            for (int n = 0; n < 10 && !seen; n++) begin
                @(negedge clk);
                seen = |bus.ch_ready;
            end
            check("rr_ready_seen", 64'(seen), 64'd1);
            t_rdy = cyc;
            if (i == 7) bus.ch_req = '0;
        end
        repeat (3) @(negedge clk);

`ifdef T02_ARB_TIMEOUT_EN
        // Bus stuck busy: error pulse instead of completion
        e.ch = 2; e.err = 1'b1; e.rdata = model_rdata;
        sb_q.push_back(e);
        bus.ch_addr[2*32 +: 32] = 32'h0000_0300;
        bus.ramload   = 32'h3333_3333;
        bus.busy_o    = 1'b1;
        bus.ch_req[2] = 1'b1;
        wait_issue(seen);
        t_iss = cyc;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = |bus.ch_err;
        end
        bus.ch_req[2] = 1'b0;
        check("to_seen", 64'(seen), 64'd1);
        check("to_latency", 64'(cyc - t_iss), 64'd9);
        check("to_strobes", 64'({bus.Ren, bus.Wen}), 64'd0);
        repeat (3) @(negedge clk);
        check("to_idle", 64'(bus.Ren | bus.Wen), 64'd0);
        bus.busy_o = 1'b0;
`else
        check("err_tied", 64'(bus.ch_err), 64'd0);
`endif

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/t02_mem_arbiter.md
Name: t02_mem_arbiter

Overview:
- Parametrised successor to the two-client (instruction/data) request unit.
- Arbitrates NUM_CH independent memory clients onto the single shared RAM bus (ramaddr/ramstore/Ren/Wen/ramload/busy_o).
- Round-robin grant, one outstanding transaction, registered bus outputs, per-channel completion pulse.
- Sits between CPU fetch/load-store/peripheral (LCD, keypad DMA) clients and the wishbone-side RAM bridge.

Parameters:
- NUM_CH, 2, number of client channels (>=2).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYC, 255, WAIT-state cycle limit (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- nrst  in  1  asynchronous active-low reset.
- enable  in  1  permits new grants; in-flight transaction always completes.
- ch_req  in  NUM_CH  per-channel request, level, held until ch_ready.
- ch_we  in  NUM_CH  per-channel write (1) / read (0).
- ch_addr  in  NUM_CH*ADDR_W  flattened addresses; channel i at [i*ADDR_W +: ADDR_W].
- ch_wdata  in  NUM_CH*DATA_W  flattened write data.
- ch_rdata  out  DATA_W  shared read data, valid in the ch_ready cycle and held until next completion.
- ch_ready  out  NUM_CH  one-hot one-cycle completion pulse.
- ch_err  out  NUM_CH  one-hot one-cycle timeout pulse (optional feature; tied 0 otherwise).
- ramaddr  out  ADDR_W  bus address.
- ramstore  out  DATA_W  bus write data.
- Ren  out  1  bus read strobe.
- Wen  out  1  bus write strobe.
- ramload  in  DATA_W  bus read data.
- busy_o  in  1  bus busy.
- grant_id  out  $clog2(NUM_CH)  index of the current or last granted channel.

Behaviour:
- Reset (async, nrst=0): state IDLE. ramaddr, ramstore, ch_rdata, ch_ready, ch_err, Ren, Wen = 0. grant_id = NUM_CH-1, so channel 0 has first priority.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If enable=1 and any ch_req: grant the first requesting channel scanning upward from grant_id+1 (mod NUM_CH).
  - Latch that channel's addr, wdata and we into ramaddr, ramstore and an internal we flag; update grant_id; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - Ren = ~we, Wen = we.
  - busy_o is ignored; go to WAIT.
- WAIT:
  - Ren/Wen stay asserted and ramaddr/ramstore stay stable.
  - When busy_o=0: capture ramload into ch_rdata (reads only; writes leave ch_rdata unchanged), deassert Ren/Wen, go to DONE.
- DONE (1 cycle):
  - ch_ready[grant_id]=1, then return to IDLE.
  - No grant is made in this cycle, so a client can drop or change its request.
- Latency: grant cycle to ch_ready is at least 3 cycles (busy_o=0 throughout); each busy cycle in WAIT adds 1.
- Back-to-back transactions: from one ch_ready to the next grant is at least 1 IDLE cycle.
- Fairness: under continuous requests from all channels, grants rotate strictly 0,1,...,NUM_CH-1,0.
- A channel that drops ch_req mid-transaction is ignored: the transaction completes and ch_ready still pulses.
- enable=0 mid-transaction has no effect until return to IDLE, where no new grant is made.
- ch_ready and ch_err are never both asserted, and never for more than one channel.
- Address and data are passed through without width conversion or alignment checks.

Optional Feature:
- Macro T02_ARB_TIMEOUT_EN.
- Defined:
  - A counter is cleared when ISSUE is entered and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYC with busy_o still 1: deassert Ren/Wen, pulse ch_err[grant_id] (not ch_ready) for 1 cycle, leave ch_rdata unchanged, go to IDLE.
- Undefined: no counter; WAIT lasts indefinitely; ch_err is constant 0.

Test Plan:
- Reset with ch_req=2'b11, then release nrst → first grant is ch0: ramaddr=ch0 addr, Ren=1 in ISSUE; ch_ready=2'b01 3 cycles after the grant with busy_o=0.
- Read with ch_addr[0]=32'h0000_0040 and busy_o high for 4 WAIT cycles, ramload=32'hDEAD_BEEF → ch_ready[0] 7 cycles after the grant; ch_rdata=32'hDEAD_BEEF.
- NUM_CH=4, all ch_req held high for 8 transactions → grant_id sequence 0,1,2,3,0,1,2,3.
- ch1 write, ch_wdata=32'h1234_5678, addr 32'h0000_0100 → Wen=1 and Ren=0 for ISSUE+WAIT; ramstore=32'h1234_5678; ch_rdata unchanged.
- Assert nrst=0 mid-WAIT → Ren=Wen=0 immediately; after release, no ch_ready pulse and the next grant restarts at ch0.
- With T02_ARB_TIMEOUT_EN and TIMEOUT_CYC=8, busy_o stuck at 1 → ch_err[grant_id] pulses 8 WAIT cycles after ISSUE; ch_ready never pulses; FSM back in IDLE.
